conv_operand_feeder: RTL and testbench



---
 rtl/conv_feeder_pkg.sv | 25 ++
 rtl/feeder_sp_ram.sv | 23 ++
 rtl/conv_operand_feeder.sv | 162 ++++++++++++++++
 tb/tb_conv_operand_feeder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/conv_feeder_pkg.sv
// Shared types and sizing helpers for the CONV operand feeder.
// The depth functions keep RAM sizing in one place for every instance.
package conv_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } feeder_state_t;

    localparam logic LOAD_SEL_IFM = 1'b0;
    localparam logic LOAD_SEL_WGT = 1'b1;

    function automatic int ifm_depth(input int ci, input int size);
        return ci * size * size;
    endfunction

    function automatic int wgt_depth(input int co, input int ci, input int k);
        return co * ci * k * k;
    endfunction

    localparam int IFM_DEPTH = ifm_depth(3, 64);
    localparam int WGT_DEPTH = wgt_depth(8, 3, 3);

endpackage

// File: rtl/feeder_sp_ram.sv
// Single-port RAM, synchronous write and registered read; contents are never reset.
module feeder_sp_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/conv_operand_feeder.sv
// Operand source for CONV: byte-stream loading of ifm/weight RAMs, then one
// operand per ifm_read/wgt_read with 1-cycle latency and wrap-around pointers.
module conv_operand_feeder
    import conv_feeder_pkg::*;
#(
    parameter int IFM_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int IFM_SIZE     = 64,
    parameter int KERNEL_SIZE  = 3,
    parameter int CI           = 3,
    parameter int CO           = 8
) (
    input  logic                    clk2,
    input  logic                    rst_n,
    input  logic                    load_start,
    input  logic                    load_sel,
    input  logic                    load_valid,
    input  logic [7:0]              load_data,
    output logic                    load_ready,
    output logic                    load_done,
    input  logic                    start_conv,
    input  logic                    end_conv,
    input  logic                    ifm_read,
    input  logic                    wgt_read,
    output logic [IFM_WIDTH-1:0]    ifm,
    output logic [WEIGHT_WIDTH-1:0] wgt,
    output logic                    ifm_valid,
    output logic                    wgt_valid,
    output logic                    busy,
    output logic                    rd_err,
    output logic [1:0]              state_dbg
);

    localparam int IFM_WORDS = ifm_depth(CI, IFM_SIZE);
    localparam int WGT_WORDS = wgt_depth(CO, CI, KERNEL_SIZE);
    localparam int IFM_AW    = $clog2(IFM_WORDS);
    localparam int WGT_AW    = $clog2(WGT_WORDS);
    localparam int WP_W      = (IFM_AW > WGT_AW) ? IFM_AW : WGT_AW;

    localparam logic [IFM_AW-1:0] IFM_LAST   = IFM_AW'(IFM_WORDS - 1);
    localparam logic [WGT_AW-1:0] WGT_LAST   = WGT_AW'(WGT_WORDS - 1);
    localparam logic [WP_W-1:0]   IFM_LAST_W = WP_W'(IFM_WORDS - 1);
    localparam logic [WP_W-1:0]   WGT_LAST_W = WP_W'(WGT_WORDS - 1);

    feeder_state_t state, state_next;
    logic [WP_W-1:0]   wptr;
    logic              target;
    logic              ifm_loaded, wgt_loaded;
    logic [IFM_AW-1:0] ifm_ptr;
    logic [WGT_AW-1:0] wgt_ptr;
    logic [IFM_WIDTH-1:0]    ifm_rdata;
    logic [WEIGHT_WIDTH-1:0] wgt_rdata;

    logic start_accept, start_reject, write_en, last_write, bad_read;
    logic ifm_rd, wgt_rd;
    logic [WP_W-1:0] load_last;

    // Handshake: in LOAD, a byte moves on every clk2 edge where load_valid and
    // load_ready are both high; read requests are sampled on clk2 and answered
    // one edge later with the matching *_valid high for exactly one cycle.
    always_comb begin
        state_next   = state;
        start_accept = 1'b0;
        start_reject = 1'b0;
        write_en     = 1'b0;
        last_write   = 1'b0;
        load_last    = (target == LOAD_SEL_WGT) ? WGT_LAST_W : IFM_LAST_W;
        bad_read     = (ifm_read || wgt_read) && (state != SERVE);
        ifm_rd       = (state == SERVE) && ifm_read;
        wgt_rd       = (state == SERVE) && wgt_read;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                end else if (start_conv) begin
                    start_accept = ifm_loaded && wgt_loaded;
                    start_reject = !(ifm_loaded && wgt_loaded);
                    if (start_accept) state_next = SERVE;
                end
            end
            LOAD: begin
                write_en   = load_valid && !load_start;
                last_write = write_en && (wptr == load_last);
                if (last_write) state_next = IDLE;
            end
            SERVE: begin
                if (end_conv) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wptr       <= '0;
            target     <= LOAD_SEL_IFM;
            ifm_loaded <= 1'b0;
            wgt_loaded <= 1'b0;
            load_done  <= 1'b0;
            ifm_ptr    <= '0;
            wgt_ptr    <= '0;
            ifm_valid  <= 1'b0;
            wgt_valid  <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            state     <= state_next;
            load_done <= last_write;
            ifm_valid <= ifm_rd;
            wgt_valid <= wgt_rd;

            // A (re)started load invalidates whatever the target RAM held.
            if (load_start && state != SERVE) begin
                wptr   <= '0;
                target <= load_sel;
                if (load_sel == LOAD_SEL_WGT) wgt_loaded <= 1'b0;
                else                          ifm_loaded <= 1'b0;
            end else if (write_en) begin
                wptr <= wptr + 1'b1;
            end
            if (last_write) begin
                if (target == LOAD_SEL_WGT) wgt_loaded <= 1'b1;
                else                        ifm_loaded <= 1'b1;
            end

            if (start_accept) begin
                ifm_ptr <= '0;
                wgt_ptr <= '0;
            end else begin
                if (ifm_rd) ifm_ptr <= (ifm_ptr == IFM_LAST) ? '0 : ifm_ptr + 1'b1;
                if (wgt_rd) wgt_ptr <= (wgt_ptr == WGT_LAST) ? '0 : wgt_ptr + 1'b1;
            end

            if (bad_read || start_reject) rd_err <= 1'b1;
            else if (start_accept)        rd_err <= 1'b0;
        end
    end

    feeder_sp_ram #(.WIDTH(IFM_WIDTH), .DEPTH(IFM_WORDS)) u_ifm_ram (
        .clk   (clk2),
        .we    (write_en && target == LOAD_SEL_IFM),
        .addr  ((state == LOAD) ? wptr[IFM_AW-1:0] : ifm_ptr),
        .wdata (load_data[IFM_WIDTH-1:0]),
        .rdata (ifm_rdata)
    );

    feeder_sp_ram #(.WIDTH(WEIGHT_WIDTH), .DEPTH(WGT_WORDS)) u_wgt_ram (
        .clk   (clk2),
        .we    (write_en && target == LOAD_SEL_WGT),
        .addr  ((state == LOAD) ? wptr[WGT_AW-1:0] : wgt_ptr),
        .wdata (load_data[WEIGHT_WIDTH-1:0]),
        .rdata (wgt_rdata)
    );

    // The RAM output register is not reset, so the buses are gated by valid.
    assign ifm        = ifm_valid ? ifm_rdata : '0;
    assign wgt        = wgt_valid ? wgt_rdata : '0;
    assign busy       = (state == SERVE);
    assign load_ready = (state == LOAD);
    assign state_dbg  = state;

endmodule

// File: tb/tb_conv_operand_feeder.sv
// Randomized bench for conv_operand_feeder against an array/queue reference model.
module tb_conv_operand_feeder;

    localparam int IFM_N = 3 * 64 * 64;
    localparam int WGT_N = 8 * 3 * 3 * 3;

    logic       clk2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0, load_sel = 1'b0, load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       start_conv = 1'b0, end_conv = 1'b0, ifm_read = 1'b0, wgt_read = 1'b0;
    logic       load_ready, load_done, ifm_valid, wgt_valid, busy, rd_err;
    logic [7:0] ifm, wgt;
    logic [1:0] state_dbg;

    conv_operand_feeder dut (
        .clk2(clk2), .rst_n(rst_n), .load_start(load_start), .load_sel(load_sel),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .load_done(load_done), .start_conv(start_conv), .end_conv(end_conv),
        .ifm_read(ifm_read), .wgt_read(wgt_read), .ifm(ifm), .wgt(wgt),
        .ifm_valid(ifm_valid), .wgt_valid(wgt_valid), .busy(busy), .rd_err(rd_err),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk2 = ~clk2;

    // reference model
    logic [7:0] ifm_m [IFM_N];
    logic [7:0] wgt_m [WGT_N];
    int  ifm_idx = 0, wgt_idx = 0;
    bit  ifm_ok = 0, wgt_ok = 0, serving = 0, err_m = 0;
    logic [7:0] exp_ifm_q[$];
    logic [7:0] exp_wgt_q[$];

    int compared = 0, mismatched = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ifm"}, ifm, 0);
        check_eq({tag, "_wgt"}, wgt, 0);
        check_eq({tag, "_ifm_valid"}, ifm_valid, 0);
        check_eq({tag, "_wgt_valid"}, wgt_valid, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_rd_err"}, rd_err, 0);
        check_eq({tag, "_load_ready"}, load_ready, 0);
        check_eq({tag, "_load_done"}, load_done, 0);
    endtask

    // One clk2 cycle of CONV-side activity, checked against the model.
    task automatic cycle(input bit ir, input bit wr, input bit ec, input bit sc);
        bit got_i, got_w;
        logic [7:0] ei, ew;
        ifm_read = ir; wgt_read = wr; end_conv = ec; start_conv = sc;
        got_i = serving && ir;
        got_w = serving && wr;
        if (got_i) begin
            exp_ifm_q.push_back(ifm_m[ifm_idx]);
            ifm_idx = (ifm_idx + 1) % IFM_N;
        end
        if (got_w) begin
            exp_wgt_q.push_back(wgt_m[wgt_idx]);
            wgt_idx = (wgt_idx + 1) % WGT_N;
        end
        if (serving) begin
            if (ec) serving = 0;
        end else begin
            if (sc && ifm_ok && wgt_ok) begin
                serving = 1; ifm_idx = 0; wgt_idx = 0; err_m = 0;
            end else if (sc) begin
                err_m = 1;
            end
            if (ir || wr) err_m = 1;
        end
        tick();
        ifm_read = 0; wgt_read = 0; end_conv = 0; start_conv = 0;
        ei = got_i ? exp_ifm_q.pop_front() : 8'h00;
        ew = got_w ? exp_wgt_q.pop_front() : 8'h00;
        check_eq("ifm", ifm, ei);
        check_eq("ifm_valid", ifm_valid, got_i);
        check_eq("wgt", wgt, ew);
        check_eq("wgt_valid", wgt_valid, got_w);
        check_eq("busy", busy, serving);
        check_eq("rd_err", rd_err, err_m);
    endtask

    // Stream a full RAM image; rnd selects random bytes instead of the ramp pattern.
    task automatic load(input bit sel, input bit rnd);
        int n, i, done_cnt;
        bit v;
        logic [7:0] d;
        n = sel ? WGT_N : IFM_N;
        i = 0;
        done_cnt = 0;
        load_sel = sel; load_start = 1; tick(); load_start = 0;
        if (sel) wgt_ok = 0; else ifm_ok = 0;
        while (i < n) begin
            v = ($urandom_range(0, 7) != 0);
            d = rnd ? 8'($urandom_range(0, 255)) : (sel ? 8'(255 - i) : 8'(i % 256));
            load_valid = v; load_data = d;
            tick();
            if (v) begin
                if (sel) wgt_m[i] = d; else ifm_m[i] = d;
                i++;
            end
            if (i < n) begin
                check_eq("load_ready", load_ready, 1);
                check_eq("load_done_early", load_done, 0);
                check_eq("busy_in_load", busy, 0);
            end
        end
        load_valid = 0;
        done_cnt += int'(load_done);
        check_eq("load_ready_after", load_ready, 0);
        tick();
        done_cnt += int'(load_done);
        check_eq("load_done_pulses", done_cnt, 1);
        if (sel) wgt_ok = 1; else ifm_ok = 1;
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 0;
        #1 check_idle_outputs(tag);
        load_start = 0; load_valid = 0; ifm_read = 0; wgt_read = 0;
        start_conv = 0; end_conv = 0;
        ifm_ok = 0; wgt_ok = 0; serving = 0; err_m = 0;
        ifm_idx = 0; wgt_idx = 0;
        exp_ifm_q.delete(); exp_wgt_q.delete();
        @(negedge clk2);
        rst_n = 1;
        tick();
    endtask

    task automatic random_reads(input int n);
        for (int k = 0; k < n; k++) begin
            cycle($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 0, 0);
        end
    endtask

    initial begin
        #2 check_idle_outputs("reset");
        @(negedge clk2);
        rst_n = 1;
        tick();

        cycle(1, 0, 0, 0);                 // read before any load
        load(0, 0);
        cycle(0, 0, 0, 1);                 // only ifm loaded: rejected
        load(1, 0);
        cycle(0, 0, 0, 1);                 // accepted, rd_err cleared
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        for (int k = 0; k < WGT_N + 1; k++) cycle(0, 1, 0, 0);
        for (int k = 0; k < IFM_N + 1; k++) cycle(1, 0, 0, 0);
        random_reads(300);

        cycle(1, 1, 1, 0);                 // read with end_conv still served
        cycle(1, 0, 0, 0);                 // now an error
        cycle(0, 0, 0, 1);
        random_reads(50);
        async_reset("rst_serve");
        cycle(0, 0, 0, 1);                 // flags lost

        load(1, 1);
        load_sel = 0; load_start = 1; tick(); load_start = 0;
        for (int k = 0; k < 20; k++) begin
            load_valid = 1; load_data = 8'($urandom_range(0, 255)); tick();
        end
        load_valid = 0;
        async_reset("rst_load");
        cycle(0, 0, 0, 1);

        load(0, 1);
        load(1, 1);
        cycle(0, 0, 0, 1);
        random_reads(400);
        cycle(0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
